// File: rtl/pc_control_unit.sv
// Program counter and next-PC select: sequential, CBZ/CBNZ, B, BR, stall, flush, sticky halt.
// Optional taken-redirect counter enabled by defining BRANCH_STATS_EN.
module pc_control_unit #(
    parameter int PC_WIDTH                   = 16,
    parameter int OFFSET_SHIFT               = 1,
    parameter int INSTR_BYTES                = 2,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch,
    input  logic                branch_nz,
    input  logic                uncond,
    input  logic                jump_reg,
    input  logic                alu_zero,
    input  logic                halt_req,
    input  logic [PC_WIDTH-1:0] signext,
    input  logic [PC_WIDTH-1:0] reg_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus,
    output logic                flush,
    output logic                halted,
    output logic                align_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]         taken_count
`endif
);

    typedef enum logic {RUN, HALTED} state_t;

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'((1 << OFFSET_SHIFT) - 1);
    localparam logic [PC_WIDTH-1:0] INC        = PC_WIDTH'(INSTR_BYTES);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                flush_q, flush_d;
    logic                align_q, align_d;
    logic                redirect;
    logic                cond_taken;
    logic [PC_WIDTH-1:0] br_off;

    assign br_off     = signext << OFFSET_SHIFT;
    assign cond_taken = uncond | (branch & alu_zero) | (branch_nz & ~alu_zero);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush_d  = 1'b0;
        align_d  = align_q;
        redirect = 1'b0;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    align_d = 1'b0;
                    if (halt_req) begin
                        state_d = HALTED;
                    end else if (jump_reg) begin
                        pc_d     = reg_target & ~ALIGN_MASK;
                        align_d  = |(reg_target & ALIGN_MASK);
                        redirect = 1'b1;
                    end else if (cond_taken) begin
                        pc_d     = pc_q + br_off;
                        redirect = 1'b1;
                    end else begin
                        pc_d = pc_q + INC;
                    end
                end
            end
            default: begin
                align_d = 1'b0;
            end
        endcase
        flush_d = redirect;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            flush_q <= 1'b0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            align_q <= align_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturate rather than wrap so a long run never reports a small count.
    always_comb begin
        cnt_d = cnt_q;
        if (redirect && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= 16'd0;
        else       cnt_q <= cnt_d;
    end

    assign taken_count = cnt_q;
`endif

    assign pc        = pc_q;
    assign pc_plus   = pc_q + INC;
    assign flush     = flush_q;
    assign halted    = (state_q == HALTED);
    assign align_err = align_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Bench for pc_control_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_pc_control_unit;

    logic        clock = 1'b0;
    logic        reset, stall, branch, branch_nz, uncond, jump_reg, alu_zero, halt_req;
    logic [15:0] signext, reg_target;
    logic [15:0] pc, pc_plus;
    logic        flush, halted, align_err;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // reference state
    logic [15:0] m_pc;
    bit          m_flush, m_halt, m_align;
    int          m_cnt;

    pc_control_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .branch(branch),
        .branch_nz(branch_nz), .uncond(uncond), .jump_reg(jump_reg),
        .alu_zero(alu_zero), .halt_req(halt_req), .signext(signext),
        .reg_target(reg_target), .pc(pc), .pc_plus(pc_plus), .flush(flush),
        .halted(halted), .align_err(align_err)
`ifdef BRANCH_STATS_EN
        , .taken_count(taken_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic clear_in();
        reset = 0; stall = 0; branch = 0; branch_nz = 0; uncond = 0;
        jump_reg = 0; alu_zero = 0; halt_req = 0; signext = 0; reg_target = 0;
    endtask

    // Advance one clock; the model applies the behavioural rules to the inputs now on the pins.
    task automatic tick();
        logic [15:0] off;
        bit          taken;
        off   = signext * 16'd2;
        taken = uncond || (branch && alu_zero) || (branch_nz && !alu_zero);
        if (reset) begin
            m_pc = 16'h0000; m_flush = 0; m_halt = 0; m_align = 0; m_cnt = 0;
        end else if (m_halt) begin
            m_flush = 0; m_align = 0;
        end else if (stall) begin
            m_flush = 0;
        end else if (halt_req) begin
            m_halt = 1; m_flush = 0; m_align = 0;
        end else if (jump_reg) begin
            m_align = (reg_target % 2) != 0;
            m_pc    = reg_target - (reg_target % 2);
            m_flush = 1;
            if (m_cnt < 65535) m_cnt++;
        end else if (taken) begin
            m_pc = m_pc + off; m_flush = 1; m_align = 0;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_pc = m_pc + 16'd2; m_flush = 0; m_align = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_pc(input logic [15:0] v);
        clear_in(); jump_reg = 1; reg_target = v; tick(); clear_in();
    endtask

    task automatic test_reset();
        clear_in(); reset = 1; stall = 1; halt_req = 1; uncond = 1; signext = 16'h0010;
        tick(); tick();
        n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL reset_pc: got %h exp 0000", pc); end
        n_vec++; if ({flush, halted, align_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b exp 000", {flush, halted, align_err}); end
        clear_in();
    endtask

    task automatic test_sequential();
        clear_in(); reset = 1; tick(); clear_in();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_vec++; if (pc !== 16'(2 * i) || flush !== 1'b0) begin n_err++; $display("FAIL seq_pc%0d: got pc=%h flush=%b exp pc=%h flush=0", i, pc, flush, 16'(2 * i)); end
            n_vec++; if (pc_plus !== 16'(2 * i + 2)) begin n_err++; $display("FAIL seq_plus%0d: got %h exp %h", i, pc_plus, 16'(2 * i + 2)); end
        end
    endtask

    task automatic test_branch();
        set_pc(16'h0010);
        branch = 1; alu_zero = 1; signext = 16'hFFFC; tick(); clear_in();
        n_vec++; if (pc !== 16'h0008 || flush !== 1'b1) begin n_err++; $display("FAIL cbz_taken: got pc=%h flush=%b exp pc=0008 flush=1", pc, flush); end
        tick();
        n_vec++; if (pc !== 16'h000A || flush !== 1'b0) begin n_err++; $display("FAIL cbz_after: got pc=%h flush=%b exp pc=000a flush=0", pc, flush); end
        set_pc(16'h0010);
        branch = 1; alu_zero = 0; signext = 16'hFFFC; tick(); clear_in();
        n_vec++; if (pc !== 16'h0012 || flush !== 1'b0) begin n_err++; $display("FAIL cbz_not: got pc=%h flush=%b exp pc=0012 flush=0", pc, flush); end
        branch_nz = 1; alu_zero = 0; signext = 16'h0003; tick(); clear_in();
        n_vec++; if (pc !== 16'h0018 || flush !== 1'b1) begin n_err++; $display("FAIL cbnz_taken: got pc=%h flush=%b exp pc=0018 flush=1", pc, flush); end
        branch = 1; branch_nz = 1; alu_zero = 1; signext = 16'h0001; tick(); clear_in();
        n_vec++; if (pc !== 16'h001A || flush !== 1'b1) begin n_err++; $display("FAIL both_taken: got pc=%h flush=%b exp pc=001a flush=1", pc, flush); end
    endtask

    task automatic test_stall();
        set_pc(16'h0020);
        uncond = 1; signext = 16'h0004; stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (pc !== 16'h0020 || flush !== 1'b0) begin n_err++; $display("FAIL stall_hold%0d: got pc=%h flush=%b exp pc=0020 flush=0", i, pc, flush); end
        end
        stall = 0; tick(); clear_in();
        n_vec++; if (pc !== 16'h0028 || flush !== 1'b1) begin n_err++; $display("FAIL stall_release: got pc=%h flush=%b exp pc=0028 flush=1", pc, flush); end
    endtask

    task automatic test_jump_reg();
        clear_in(); jump_reg = 1; reg_target = 16'h1235; tick();
        n_vec++; if (pc !== 16'h1234 || align_err !== 1'b1 || flush !== 1'b1) begin n_err++; $display("FAIL br_misalign: got pc=%h ae=%b fl=%b exp pc=1234 ae=1 fl=1", pc, align_err, flush); end
        reg_target = 16'h2000; tick();
        n_vec++; if (pc !== 16'h2000 || align_err !== 1'b0 || flush !== 1'b1) begin n_err++; $display("FAIL br_aligned: got pc=%h ae=%b fl=%b exp pc=2000 ae=0 fl=1", pc, align_err, flush); end
        reg_target = 16'h3000; uncond = 1; signext = 16'h0004; tick(); clear_in();
        n_vec++; if (pc !== 16'h3000) begin n_err++; $display("FAIL br_priority: got %h exp 3000", pc); end
        jump_reg = 1; reg_target = 16'h4001; tick(); clear_in(); tick();
        n_vec++; if (align_err !== 1'b0 || pc !== 16'h4002) begin n_err++; $display("FAIL br_ae_pulse: got ae=%b pc=%h exp ae=0 pc=4002", align_err, pc); end
    endtask

    task automatic test_wrap();
        set_pc(16'hFFFE);
        n_vec++; if (pc_plus !== 16'h0000) begin n_err++; $display("FAIL wrap_plus: got %h exp 0000", pc_plus); end
        tick();
        n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL wrap_pc: got %h exp 0000", pc); end
    endtask

    task automatic test_halt();
        set_pc(16'h0040);
        halt_req = 1; tick(); clear_in();
        n_vec++; if (pc !== 16'h0040 || halted !== 1'b1) begin n_err++; $display("FAIL halt_enter: got pc=%h h=%b exp pc=0040 h=1", pc, halted); end
        uncond = 1; signext = 16'h0004; jump_reg = 1; reg_target = 16'h0101;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (pc !== 16'h0040 || halted !== 1'b1 || flush !== 1'b0 || align_err !== 1'b0) begin n_err++; $display("FAIL halt_hold%0d: got pc=%h h=%b fl=%b ae=%b exp pc=0040 h=1 fl=0 ae=0", i, pc, halted, flush, align_err); end
        end
        clear_in(); reset = 1; tick(); clear_in();
        n_vec++; if (pc !== 16'h0000 || halted !== 1'b0) begin n_err++; $display("FAIL halt_reset: got pc=%h h=%b exp pc=0000 h=0", pc, halted); end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        clear_in(); reset = 1; tick(); clear_in();
        for (int i = 0; i < 3; i++) begin uncond = 1; signext = 16'h0002; tick(); clear_in(); end
        tick(); tick();
        stall = 1; uncond = 1; signext = 16'h0002; tick();
        n_vec++; if (taken_count !== 16'd3) begin n_err++; $display("FAIL stats_stalled: got %0d exp 3", taken_count); end
        stall = 0; tick(); clear_in();
        n_vec++; if (taken_count !== 16'd4) begin n_err++; $display("FAIL stats_release: got %0d exp 4", taken_count); end
        reset = 1; tick(); clear_in();
        n_vec++; if (taken_count !== 16'd0) begin n_err++; $display("FAIL stats_reset: got %0d exp 0", taken_count); end
    endtask
`endif

    task automatic test_random();
        clear_in(); reset = 1; tick(); clear_in();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            halt_req   = ($urandom_range(0, 39) == 0);
            jump_reg   = ($urandom_range(0, 7) == 0);
            uncond     = ($urandom_range(0, 7) == 0);
            branch     = ($urandom_range(0, 3) == 0);
            branch_nz  = ($urandom_range(0, 3) == 0);
            alu_zero   = $urandom_range(0, 1);
            signext    = 16'($urandom);
            reg_target = 16'($urandom);
            tick();
            n_vec++; if (pc !== m_pc || pc_plus !== m_pc + 16'd2) begin n_err++; $display("FAIL rnd_pc%0d: got pc=%h plus=%h exp pc=%h", i, pc, pc_plus, m_pc); end
            n_vec++; if ({flush, halted, align_err} !== {m_flush, m_halt, m_align}) begin n_err++; $display("FAIL rnd_flags%0d: got %b exp %b", i, {flush, halted, align_err}, {m_flush, m_halt, m_align}); end
`ifdef BRANCH_STATS_EN
            n_vec++; if (taken_count !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt%0d: got %0d exp %0d", i, taken_count, m_cnt); end
`endif
        end
        clear_in();
    endtask

    initial begin
        m_pc = 0; m_flush = 0; m_halt = 0; m_align = 0; m_cnt = 0;
        clear_in();
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_jump_reg();
        test_wrap();
        test_halt();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_control_unit.md
Name: pc_control_unit

Overview:
Parametrised program counter and next-PC selection for the LEGLite core. It replaces the fixed 16-bit, CBZ-only PC logic with the following:
- configurable width and instruction size;
- CBZ, CBNZ, unconditional B and register-indirect BR;
- pipeline stall;
- a one-cycle flush pulse on every redirect;
- a sticky HALT state.

It sits at the front of the datapath, feeding instruction memory and the branch-target adder.

Parameters:
PC_WIDTH, 16, width of pc and all target arithmetic
OFFSET_SHIFT, 1, left shift applied to signext (log2 of instruction bytes)
INSTR_BYTES, 2, sequential increment
RESET_VECTOR, 0, pc value loaded on reset

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high
stall  input  1  hold pc; all control inputs ignored this cycle
branch  input  1  CBZ: taken when alu_zero=1
branch_nz  input  1  CBNZ: taken when alu_zero=0
uncond  input  1  B: always taken, PC-relative
jump_reg  input  1  BR: pc <= reg_target
alu_zero  input  1  zero flag from ALU
halt_req  input  1  enter HALTED state
signext  input  PC_WIDTH  sign-extended offset in instructions
reg_target  input  PC_WIDTH  absolute target for BR
pc  output  PC_WIDTH  current program counter
pc_plus  output  PC_WIDTH  pc + INSTR_BYTES, combinational (link value)
flush  output  1  registered; high the cycle after a taken redirect
halted  output  1  high while in HALTED
align_err  output  1  registered; high the cycle after a BR with misaligned target

Behaviour:
- Reset
  - Synchronous reset dominates all other inputs, including stall and halt_req.
  - Reset values: pc=RESET_VECTOR, flush=0, halted=0, align_err=0, state=RUN.
  - Reset asserted in HALTED returns the block to RUN.
- States: RUN and HALTED.
  - RUN -> HALTED when halt_req=1 and stall=0. pc holds at its current value; the halt_req cycle does not advance pc.
  - HALTED -> RUN only by reset. In HALTED, pc holds and every input other than reset is ignored; flush=0 and align_err=0.
- Next pc in RUN when stall=0. First match wins:
  1. halt_req: pc holds.
  2. jump_reg: pc <= reg_target with low OFFSET_SHIFT bits forced to 0. align_err <= 1 if any of those bits were nonzero, else 0.
  3. uncond: pc <= pc + (signext << OFFSET_SHIFT).
  4. branch and alu_zero=1, or branch_nz and alu_zero=0: pc <= pc + (signext << OFFSET_SHIFT).
  5. Otherwise: pc <= pc + INSTR_BYTES.
- stall=1 in RUN: pc, state and align_err hold; flush <= 0. Upstream must keep control inputs stable until stall deasserts; nothing is queued.
- flush <= 1 for exactly one cycle after any taken redirect (items 2-4), else 0. Back-to-back redirects give back-to-back flush pulses.
- branch and branch_nz both high: taken iff its condition term is satisfied. Since exactly one of the two conditions holds for any alu_zero, this is always taken.
- Arithmetic:
  - All arithmetic is modulo 2^PC_WIDTH; wrap-around is silent. Example: PC_WIDTH=16, pc=0xFFFE increments to 0x0000.
  - Negative signext is two's complement; the shifted offset is truncated to PC_WIDTH.
- Latency: one cycle from control inputs to new pc. pc_plus tracks pc combinationally.

Optional Feature:
Macro BRANCH_STATS_EN.
- Defined: adds output taken_count [15:0]. It increments, saturating at 0xFFFF, on each cycle where a taken redirect updates pc. It resets to 0 with reset and holds during stall and in HALTED.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset then 4 cycles with no controls, defaults -> pc = 0x0000, 0x0002, 0x0004, 0x0006, 0x0008; flush=0 throughout.
2. pc=0x0010, branch=1, alu_zero=1, signext=0xFFFC -> pc=0x0008 next cycle, flush=1 for one cycle. Same with alu_zero=0 -> pc=0x0012, flush=0.
3. pc=0x0020, stall=1 for 3 cycles with uncond=1, signext=0x0004 -> pc holds at 0x0020. Stall drops -> pc=0x0028, flush=1.
4. jump_reg=1, reg_target=0x1235 -> pc=0x1234, align_err=1 for one cycle. reg_target=0x2000 -> pc=0x2000, align_err=0. jump_reg together with uncond -> jump_reg wins.
5. pc=0xFFFE with no controls -> pc=0x0000. halt_req at pc=0x0040 -> pc stays 0x0040 and halted=1 for 5 cycles despite uncond=1. reset -> pc=0, halted=0.
6. With BRANCH_STATS_EN: 3 taken branches, 2 not-taken, 1 stalled uncond -> taken_count=3. After stall release -> taken_count=4. reset -> taken_count=0.
